// File: rtl/nco_quad_if.sv
// nco_quad_if -- tuning / sample bus of the quadrature NCO.
//   master : tuning logic / mixer side (drives controls, receives samples)
//   slave  : the NCO itself
// Signals:
//   en            accumulator advance enable
//   phase_clr     synchronous accumulator clear
//   phase_inc_in  new phase increment, taken on load_valid && load_ready
//   load_valid    increment load request
//   load_ready    NCO can accept a load (no increment pending)
//   phase_off_in  phase offset, sampled every cycle
//   phase_accum   accumulator register
//   sin_out       signed sine sample
//   cos_out       signed cosine sample
//   out_valid     sample qualifier (en delayed by the pipeline depth)
interface nco_quad_if #(
  parameter int PHASE_W = 64,
  parameter int AMP_W   = 16
);
  logic                      en;
  logic                      phase_clr;
  logic [PHASE_W-1:0]        phase_inc_in;
  logic                      load_valid;
  logic                      load_ready;
  logic [PHASE_W-1:0]        phase_off_in;
  logic [PHASE_W-1:0]        phase_accum;
  logic signed [AMP_W-1:0]   sin_out;
  logic signed [AMP_W-1:0]   cos_out;
  logic                      out_valid;

  modport master (
    output en, phase_clr, phase_inc_in, load_valid, phase_off_in,
    input  load_ready, phase_accum, sin_out, cos_out, out_valid
  );

  modport slave (
    input  en, phase_clr, phase_inc_in, load_valid, phase_off_in,
    output load_ready, phase_accum, sin_out, cos_out, out_valid
  );
endinterface

// File: rtl/nco_quad.sv
// nco_quad -- parameterised quadrature NCO.
//   Phase accumulator with handshaked increment load (immediate or
//   applied at accumulator wrap for phase-continuous retuning), phase
//   offset add, quarter-wave sine ROM, signed sin/cos outputs.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nco_quad_if.slave (controls in, accumulator/samples out)
// Latency: sin/cos in cycle n+3 reflect phase_accum(n)+phase_off_in(n);
// out_valid(n+3) = en(n).

// One output lane: quadrant fold, ROM read (S2) and sign apply (S3).
// QOFF rotates the quadrant: 0 gives sine, 1 gives cosine.
module nco_quad_lane #(
  parameter int PHASE_W    = 64,
  parameter int LUT_ADDR_W = 10,
  parameter int AMP_W      = 16,
  parameter int QOFF       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] ph_i,
  output logic [AMP_W-1:0]   smp_o
);
  localparam int  N   = 1 << LUT_ADDR_W;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'((2 ** (AMP_W-1)) - 1);

  // Quarter-wave magnitudes sampled at half-step offsets, so no entry is
  // zero and the folded waveform is odd-symmetric without a special case.
  logic [AMP_W-2:0] rom [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam real ANG = 2.0 * PI * (real'(k) + 0.5) / (4.0 * real'(N));
    assign rom[k] = (AMP_W-1)'($rtoi(AMP * $sin(ANG) + 0.5));
  end

  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx, addr;
  logic                  unused_ph;

  assign quad = ph_i[PHASE_W-1 -: 2] + 2'(QOFF);
  assign idx  = ph_i[PHASE_W-3 -: LUT_ADDR_W];
  // Odd quadrants run the table backwards: N-1-i is ~i for a power of 2.
  assign addr = quad[0] ? ~idx : idx;
  // Only the top LUT_ADDR_W+2 phase bits address the table (truncation).
  assign unused_ph = ^ph_i;

  logic [AMP_W-2:0] mag_q;
  logic             neg_q;
  logic [AMP_W-1:0] smp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      neg_q <= 1'b0;
      smp_q <= '0;
    end else begin
      mag_q <= rom[addr];
      neg_q <= quad[1];
      smp_q <= neg_q ? ({AMP_W{1'b0}} - {1'b0, mag_q}) : {1'b0, mag_q};
    end
  end

  assign smp_o = smp_q;
endmodule

module nco_quad #(
  parameter int PHASE_W     = 64,
  parameter int LUT_ADDR_W  = 10,
  parameter int AMP_W       = 16,
  parameter int UPDATE_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  nco_quad_if.slave  bus
);
  localparam int STAGES    = 3;
  localparam int NUM_LANES = 2;   // lane 0 = sin, lane 1 = cos

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_act_q, inc_act_d;
  logic [PHASE_W-1:0] inc_sh_q, inc_sh_d;
  logic               pend_q, pend_d;
  logic [PHASE_W-1:0] ph_q;
  logic [STAGES:1]    vld_pipe;

  logic [PHASE_W:0]   acc_sum;
  logic               wrap, hs, apply;

  logic [NUM_LANES-1:0][AMP_W-1:0] smp;

  always_comb begin
    acc_d     = acc_q;
    inc_act_d = inc_act_q;
    inc_sh_d  = inc_sh_q;
    pend_d    = pend_q;

    acc_sum = {1'b0, acc_q} + {1'b0, inc_act_q};
    // A clear counts as a wrap so a pending retune lands on a clean phase.
    wrap    = (bus.en && acc_sum[PHASE_W]) || bus.phase_clr;
    hs      = bus.load_valid && !pend_q;

    // Mode 1 waits for a wrap, except with a zero increment: the
    // accumulator would never wrap and the load would stall forever.
    if (UPDATE_MODE == 0) apply = pend_q;
    else                  apply = pend_q && (wrap || (inc_act_q == '0));

    // Accumulator always advances with the increment that was active
    // before this edge, including on the edge that applies a new one.
    if (bus.phase_clr)  acc_d = '0;
    else if (bus.en)    acc_d = acc_sum[PHASE_W-1:0];

    // apply requires pend_q and hs requires !pend_q, so a capture made on
    // a wrap edge is never applied on that same edge.
    if (apply) begin
      inc_act_d = inc_sh_q;
      pend_d    = 1'b0;
    end
    if (hs) begin
      inc_sh_d = bus.phase_inc_in;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      inc_act_q <= '0;
      inc_sh_q  <= '0;
      pend_q    <= 1'b0;
      ph_q      <= '0;
      vld_pipe  <= '0;
    end else begin
      acc_q     <= acc_d;
      inc_act_q <= inc_act_d;
      inc_sh_q  <= inc_sh_d;
      pend_q    <= pend_d;
      ph_q      <= acc_q + bus.phase_off_in;                // S1
      vld_pipe  <= {vld_pipe[STAGES-1:1], bus.en};
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    nco_quad_lane #(
      .PHASE_W    (PHASE_W),
      .LUT_ADDR_W (LUT_ADDR_W),
      .AMP_W      (AMP_W),
      .QOFF       (l)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ph_i  (ph_q),
      .smp_o (smp[l])
    );
  end

  assign bus.load_ready  = !pend_q;
  assign bus.phase_accum = acc_q;
  assign bus.sin_out     = smp[0];
  assign bus.cos_out     = smp[1];
  assign bus.out_valid   = vld_pipe[STAGES];
endmodule

// File: tb/tb_nco_quad.sv
// tb_nco_quad -- directed bench for nco_quad (PHASE_W=32, LUT_ADDR_W=8,
// AMP_W=16). u_dut0 runs UPDATE_MODE 0 against a scoreboard fed by a
// reference model; u_dut1 runs UPDATE_MODE 1 with directed expectations.
module tb_nco_quad;
  logic clk;
  logic rst_n;

  nco_quad_if #(.PHASE_W(32), .AMP_W(16)) b0 ();
  nco_quad_if #(.PHASE_W(32), .AMP_W(16)) b1 ();

  nco_quad #(.PHASE_W(32), .LUT_ADDR_W(8), .AMP_W(16), .UPDATE_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  nco_quad #(.PHASE_W(32), .LUT_ADDR_W(8), .AMP_W(16), .UPDATE_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int                 due;
    logic               v;
    logic signed [15:0] s;
    logic signed [15:0] c;
  } exp_t;
  exp_t sb[$];

  // reference model state for the mode-0 DUT
  logic [31:0] m_acc, m_inc, m_sh;
  logic        m_pend;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Ideal sample at the centre of the 2^10-step phase bin.
  function automatic logic signed [15:0] exp_smp(input logic [31:0] ph, input bit is_cos);
    int  m;
    int  v;
    real th, r;
    m  = int'(ph[31:22]);
    th = 2.0 * 3.14159265358979323846 * (real'(m) + 0.5) / 1024.0;
    r  = 32767.0 * (is_cos ? $cos(th) : $sin(th));
    v  = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    return 16'(v);
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("out_valid", 32'(b0.out_valid), 32'(e.v));
      chk("sin_out",   32'(b0.sin_out),   32'(e.s));
      chk("cos_out",   32'(b0.cos_out),   32'(e.c));
    end
  end

  // One cycle on the mode-0 DUT; called just after a falling edge.
  task automatic step0(input logic en, input logic clr, input logic lv,
                       input logic [31:0] inc, input logic [31:0] off);
    logic [31:0] ph, nacc;
    exp_t        e;
    chk("acc0", b0.phase_accum, m_acc);
    chk("rdy0", 32'(b0.load_ready), 32'(!m_pend));
    b0.en = en; b0.phase_clr = clr; b0.load_valid = lv;
    b0.phase_inc_in = inc; b0.phase_off_in = off;
    ph    = m_acc + off;
    e.due = cyc + 3;
    e.v   = en;
    e.s   = exp_smp(ph, 1'b0);
    e.c   = exp_smp(ph, 1'b1);
    sb.push_back(e);
    nacc = clr ? 32'h0 : (en ? m_acc + m_inc : m_acc);
    if (m_pend) begin
      m_inc  = m_sh;
      m_pend = 1'b0;
    end else if (lv) begin
      m_sh   = inc;
      m_pend = 1'b1;
    end
    m_acc = nacc;
    @(negedge clk);
  endtask

  // One cycle on the mode-1 DUT, then check accumulator and ready.
  task automatic step1(input logic en, input logic clr, input logic lv,
                       input logic [31:0] inc, input logic [31:0] exp_acc,
                       input logic exp_rdy, input string tag);
    b1.en = en; b1.phase_clr = clr; b1.load_valid = lv;
    b1.phase_inc_in = inc; b1.phase_off_in = 32'h0;
    @(negedge clk);
    chk({tag, "_acc"}, b1.phase_accum, exp_acc);
    chk({tag, "_rdy"}, 32'(b1.load_ready), 32'(exp_rdy));
  endtask

  initial begin
    rst_n = 1'b1;
    b0.en = 0; b0.phase_clr = 0; b0.load_valid = 0; b0.phase_inc_in = 0; b0.phase_off_in = 0;
    b1.en = 0; b1.phase_clr = 0; b1.load_valid = 0; b1.phase_inc_in = 0; b1.phase_off_in = 0;
    m_acc = 0; m_inc = 0; m_sh = 0; m_pend = 0;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rdy",   32'(b0.load_ready), 32'd1);
    chk("rst_acc",   b0.phase_accum, 32'h0);
    chk("rst_sin",   32'(b0.sin_out), 32'h0);
    chk("rst_cos",   32'(b0.cos_out), 32'h0);
    chk("rst_vld",   32'(b0.out_valid), 32'h0);
    chk("rst_rdy1",  32'(b1.load_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // mode 0: load quarter-turn increment, then run
    step0(0, 0, 1, 32'h4000_0000, 32'h0);
    step0(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step0(1, 0, 0, 32'h0, 32'h0);
    // half-turn offset: samples negated
    for (int i = 0; i < 4; i++) step0(1, 0, 0, 32'h0, 32'h8000_0000);
    // enable low: accumulator holds, valid drops 3 cycles later
    for (int i = 0; i < 5; i++) step0(0, 0, 0, 32'h0, 32'h0);
    step0(1, 0, 0, 32'h0, 32'h0);                 // -> 0x8000_0000
    step0(1, 1, 0, 32'h0, 32'h0);                 // clear wins over en
    step0(1, 0, 1, 32'h1000_0000, 32'h0);         // retune while running
    for (int i = 0; i < 6; i++) step0(1, 0, 0, 32'h0, $urandom());
    for (int i = 0; i < 4; i++) step0(1, 0, 0, 32'h0, 32'h0);

    // asynchronous reset mid-run, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", b0.phase_accum, 32'h0);
    chk("mid_rst_sin", 32'(b0.sin_out), 32'h0);
    chk("mid_rst_cos", 32'(b0.cos_out), 32'h0);
    chk("mid_rst_vld", 32'(b0.out_valid), 32'h0);
    chk("mid_rst_rdy", 32'(b0.load_ready), 32'd1);
    sb.delete();
    m_acc = 0; m_inc = 0; m_sh = 0; m_pend = 0;
    b0.en = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // mode 1: zero increment -> load applies on next edge
    step1(0, 0, 1, 32'h4000_0000, 32'h0,         0, "m1_cap");
    step1(0, 0, 0, 32'h0,         32'h0,         1, "m1_zero_apply");
    step1(1, 0, 0, 32'h0,         32'h4000_0000, 1, "m1_run");
    // retune waits for the wrap
    step1(1, 0, 1, 32'h2000_0000, 32'h8000_0000, 0, "m1_ld");
    step1(1, 0, 0, 32'h0,         32'hC000_0000, 0, "m1_wait");
    step1(1, 0, 0, 32'h0,         32'h0,         1, "m1_wrap");
    step1(1, 0, 0, 32'h0,         32'h2000_0000, 1, "m1_newinc");
    step1(1, 0, 0, 32'h0,         32'h4000_0000, 1, "m1_run2");
    // clear with pending applies the shadow
    step1(1, 0, 1, 32'h1000_0000, 32'h6000_0000, 0, "m1_ld2");
    step1(1, 0, 0, 32'h0,         32'h8000_0000, 0, "m1_wait2");
    step1(1, 1, 0, 32'h0,         32'h0,         1, "m1_clr_apply");
    step1(1, 0, 0, 32'h0,         32'h1000_0000, 1, "m1_inc1");
    for (int i = 0; i < 14; i++)
      step1(1, 0, 0, 32'h0, 32'((i + 2) * 32'h1000_0000), 1, "m1_climb");
    // load coinciding with a wrap: captured, not applied at that wrap
    step1(1, 0, 1, 32'h4000_0000, 32'h0,         0, "m1_wrap_cap");
    step1(1, 0, 0, 32'h0,         32'h1000_0000, 0, "m1_wrap_hold");
    step1(0, 1, 0, 32'h0,         32'h0,         1, "m1_clr_apply2");
    step1(1, 0, 0, 32'h0,         32'h4000_0000, 1, "m1_inc4");

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
